pattern_gen: RTL and testbench

//  Parametrised, pipelined video test-pattern generator; successor to the combinational RGB gradient source.

---
 rtl/pattern_gen_pkg.sv | 30 +++
 rtl/pattern_gen_bar_index_dec.sv | 31 +++
 rtl/pattern_gen.sv | 115 +++++++++++
 tb/tb_pattern_gen.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_gen_pkg.sv
// Shared mode encodings and the colour-bar palette for the test-pattern generator.
package pattern_gen_pkg;

  typedef enum logic [2:0] {
    MODE_GRAD  = 3'd0,
    MODE_BARS  = 3'd1,
    MODE_CHK   = 3'd2,
    MODE_SOLID = 3'd3
  } mode_e;

  localparam int NUM_BARS = 8;

  // Bar palette as {r,g,b} full-scale flags: white,yellow,cyan,green,magenta,red,blue,black.
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] rgb;
    rgb = 3'b000;
    case (idx)
      3'd0: rgb = 3'b111;
      3'd1: rgb = 3'b110;
      3'd2: rgb = 3'b011;
      3'd3: rgb = 3'b010;
      3'd4: rgb = 3'b101;
      3'd5: rgb = 3'b100;
      3'd6: rgb = 3'b001;
      default: rgb = 3'b000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/pattern_gen_bar_index_dec.sv
// Maps a horizontal pixel position to one of eight equal-width colour bars.
// Combinational, no backpressure; thresholds are elaboration-time constants.
module bar_index_dec #(
  parameter int HW       = 10,
  parameter int H_ACTIVE = 640
) (
  input  logic [HW-1:0] hc,
  output logic [2:0]    idx
);

  localparam int TW = HW + 3;

  logic [TW-1:0] hc_ext;
  logic [6:0]    ge;

  assign hc_ext = TW'(hc);

  for (genvar k = 1; k < 8; k++) begin : g_th
    localparam logic [TW-1:0] TH = TW'((k * H_ACTIVE) / 8);
    assign ge[k-1] = (hc_ext >= TH);
  end

  // Thresholds ascend, so the highest one passed names the bar; past H_ACTIVE stays at 7.
  always_comb begin
    idx = 3'd0;
    for (int k = 0; k < 7; k++) begin
      if (ge[k]) idx = 3'(k + 1);
    end
  end

endmodule

// File: rtl/pattern_gen.sv
// Pipelined video test-pattern generator: gradient, colour bars, scrolling checker, solid.
// Latency 2 clk, 1 pixel/clk; no backpressure (free-running video stream).
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int CW       = 8,
  parameter int HW       = 10,
  parameter int VW       = 10,
  parameter int FW       = 8,
  parameter int H_ACTIVE = 640,
  parameter int CHK_LOG2 = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            vidon,
  input  logic [HW-1:0]   hc,
  input  logic [VW-1:0]   vc,
  input  logic [2:0]      mode,
  input  logic            mode_valid,
  input  logic [3*CW-1:0] solid_rgb,
  output logic [CW-1:0]   r,
  output logic [CW-1:0]   g,
  output logic [CW-1:0]   b,
  output logic            de_out,
  output logic [FW-1:0]   frame_cnt
);

  logic            fs;
  logic            s1_vidon;
  logic [HW-1:0]   s1_hc;
  logic [VW-1:0]   s1_vc;
  logic [2:0]      pending;
  logic [2:0]      active;
  logic [3*CW-1:0] solid_q;
  logic [2:0]      bar_idx;
  logic [2:0]      bar;
  logic [HW-1:0]   chk_x;
  logic            sq;
  logic [3*CW-1:0] pix_nxt;
  logic            unused_bits;

  assign fs = (hc == '0) && (vc == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vidon <= 1'b0;
      s1_hc    <= '0;
      s1_vc    <= '0;
    end else begin
      s1_vidon <= vidon;
      s1_hc    <= hc;
      s1_vc    <= vc;
    end
  end

  // Mode, solid colour and frame count only move at frame start, so pixel (0,0)
  // already sees the new values when it reaches stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= 3'd0;
      active    <= 3'd0;
      solid_q   <= '0;
      frame_cnt <= '0;
    end else begin
      if (mode_valid) pending <= mode;
      if (fs) begin
        active    <= mode_valid ? mode : pending;
        solid_q   <= solid_rgb;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  bar_index_dec #(
    .HW       (HW),
    .H_ACTIVE (H_ACTIVE)
  ) u_bar_index_dec (
    .hc  (s1_hc),
    .idx (bar_idx)
  );

  assign bar   = bar_rgb(bar_idx);
  assign chk_x = s1_hc + HW'(frame_cnt);
  assign sq    = chk_x[CHK_LOG2] ^ s1_vc[CHK_LOG2];

  always_comb begin
    pix_nxt = '0;
    case (active)
      MODE_GRAD:  pix_nxt = {CW'(s1_hc), CW'(s1_vc), CW'(s1_vc)};
      MODE_BARS:  pix_nxt = {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}};
      MODE_CHK:   pix_nxt = {(3*CW){sq}};
      MODE_SOLID: pix_nxt = solid_q;
      default:    pix_nxt = '0;
    endcase
    if (!s1_vidon) pix_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r      <= '0;
      g      <= '0;
      b      <= '0;
      de_out <= 1'b0;
    end else begin
      r      <= pix_nxt[3*CW-1:2*CW];
      g      <= pix_nxt[2*CW-1:CW];
      b      <= pix_nxt[CW-1:0];
      de_out <= s1_vidon;
    end
  end

  // Only a few bits of these feed the colour logic; fold the rest away.
  assign unused_bits = ^{chk_x, s1_vc};

endmodule

// File: tb/tb_pattern_gen.sv
// Randomised and directed bench for pattern_gen against a pixel-level reference model.
module tb_pattern_gen;

  logic        clk;
  logic        rst_n;
  logic        vidon;
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic [2:0]  mode;
  logic        mode_valid;
  logic [23:0] solid_rgb;
  logic [7:0]  r, g, b;
  logic        de_out;
  logic [7:0]  frame_cnt;

  int checks;
  int errors;

  pattern_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vidon      (vidon),
    .hc         (hc),
    .vc         (vc),
    .mode       (mode),
    .mode_valid (mode_valid),
    .solid_rgb  (solid_rgb),
    .r          (r),
    .g          (g),
    .b          (b),
    .de_out     (de_out),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: what the generator should be showing for the current frame.
  int          m_pending;
  int          m_active;
  int          m_frame;
  logic [23:0] m_solid;

  logic [23:0] bar_col [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  typedef struct packed {
    logic [24:0] exp;
    logic        has_spec;
    logic [24:0] spec;
    logic [9:0]  h;
    logic [9:0]  v;
  } ent_t;

  ent_t q[$];

  function automatic logic [24:0] model_px(input logic vid, input int h, input int v);
    int idx;
    int x;
    int sq;
    logic [23:0] c;
    c = 24'h0;
    if (!vid) return 25'd0;
    case (m_active)
      0: c = {8'(h % 256), 8'(v % 256), 8'(v % 256)};
      1: begin
        idx = (h * 8) / 640;
        if (idx > 7) idx = 7;
        c = bar_col[idx];
      end
      2: begin
        x  = (h + m_frame) % 1024;
        sq = ((x / 32) % 2) ^ ((v / 32) % 2);
        c  = (sq != 0) ? 24'hFFFFFF : 24'h000000;
      end
      3: c = m_solid;
      default: c = 24'h000000;
    endcase
    return {1'b1, c};
  endfunction

  // Drive one pixel; the output checked after this edge belongs to the pixel driven one call earlier.
  task automatic pix(input logic vid, input int h, input int v, input logic mv,
                     input logic [2:0] m, input logic [23:0] srgb,
                     input logic hs, input logic [24:0] sv);
    ent_t e;
    ent_t o;
    @(negedge clk);
    vidon      = vid;
    hc         = h[9:0];
    vc         = v[9:0];
    mode_valid = mv;
    mode       = m;
    solid_rgb  = srgb;
    if (mv) m_pending = int'(m);
    if (h == 0 && v == 0) begin
      m_active = m_pending;
      m_solid  = srgb;
      m_frame  = (m_frame + 1) % 256;
    end
    e          = '0;
    e.exp      = model_px(vid, h, v);
    e.has_spec = hs;
    e.spec     = sv;
    e.h        = h[9:0];
    e.v        = v[9:0];
    q.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    if (frame_cnt !== 8'(m_frame)) begin
      errors++;
      $display("FAIL frame_cnt: got %0d expected %0d", frame_cnt, m_frame);
    end
    if (q.size() == 2) begin
      o = q.pop_front();
      checks++;
      if ({de_out, r, g, b} !== o.exp) begin
        errors++;
        $display("FAIL pixel h=%0d v=%0d: got de=%b rgb=%h expected de=%b rgb=%h",
                 o.h, o.v, de_out, {r, g, b}, o.exp[24], o.exp[23:0]);
      end
      if (o.has_spec) begin
        checks++;
        if ({de_out, r, g, b} !== o.spec) begin
          errors++;
          $display("FAIL spec_pixel h=%0d v=%0d: got de=%b rgb=%h required de=%b rgb=%h",
                   o.h, o.v, de_out, {r, g, b}, o.spec[24], o.spec[23:0]);
        end
      end
    end
  endtask

  task automatic test_reset(input string tag);
    ent_t e;
    @(negedge clk);
    vidon      = 1'b0;
    hc         = 10'd5;
    vc         = 10'd5;
    mode_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({de_out, r, g, b, frame_cnt} !== 33'd0) begin
      errors++;
      $display("FAIL reset_%s: got de=%b rgb=%h frame=%0d expected all zero",
               tag, de_out, {r, g, b}, frame_cnt);
    end
    m_pending = 0;
    m_active  = 0;
    m_frame   = 0;
    m_solid   = 24'h0;
    q.delete();
    e = '0;
    q.push_back(e);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_gradient();
    pix(1'b1, 'h1A5, 'h03C, 1'b0, 3'd0, 24'h0, 1'b1, {1'b1, 24'hA53C3C});
    pix(1'b0, 'h1A5, 'h03C, 1'b0, 3'd0, 24'h0, 1'b1, 25'd0);
    for (int i = 0; i < 20; i++)
      pix(1'b1, int'($urandom_range(1, 799)), int'($urandom_range(1, 524)),
          1'b0, 3'd0, 24'h0, 1'b0, 25'd0);
  endtask

  task automatic test_bars();
    pix(1'b1, 0,   0, 1'b1, 3'd1, 24'h0, 1'b1, {1'b1, 24'hFFFFFF});
    pix(1'b1, 79,  3, 1'b0, 3'd0, 24'h0, 1'b1, {1'b1, 24'hFFFFFF});
    pix(1'b1, 80,  3, 1'b0, 3'd0, 24'h0, 1'b1, {1'b1, 24'hFFFF00});
    pix(1'b1, 639, 3, 1'b0, 3'd0, 24'h0, 1'b1, {1'b1, 24'h000000});
    pix(1'b1, 700, 3, 1'b0, 3'd0, 24'h0, 1'b1, {1'b1, 24'h000000});
    for (int i = 0; i < 40; i++)
      pix(1'b1, int'($urandom_range(1, 799)), 7, 1'b0, 3'd0, 24'h0, 1'b0, 25'd0);
  endtask

  task automatic test_mode_timing();
    pix(1'b1, 0,   0,   1'b0, 3'd0, 24'h0, 1'b0, 25'd0);
    pix(1'b1, 100, 200, 1'b1, 3'd2, 24'h0, 1'b1, {1'b1, 24'hFFFF00});
    pix(1'b1, 300, 200, 1'b0, 3'd0, 24'h0, 1'b1, {1'b1, 24'h00FF00});
    pix(1'b1, 0,   0,   1'b0, 3'd0, 24'h0, 1'b0, 25'd0);
    for (int i = 0; i < 10; i++)
      pix(1'b1, i * 37, 40, 1'b0, 3'd0, 24'h0, 1'b0, 25'd0);
    pix(1'b1, 5, 5, 1'b1, 3'd3, 24'h0, 1'b0, 25'd0);
    pix(1'b1, 6, 5, 1'b1, 3'd1, 24'h0, 1'b0, 25'd0);
    pix(1'b1, 7, 5, 1'b0, 3'd0, 24'h0, 1'b0, 25'd0);
    pix(1'b1, 0, 0, 1'b0, 3'd0, 24'h0, 1'b1, {1'b1, 24'hFFFFFF});
    pix(1'b1, 90, 0, 1'b0, 3'd0, 24'h0, 1'b1, {1'b1, 24'hFFFF00});
  endtask

  task automatic test_checker();
    test_reset("pre_checker");
    pix(1'b0, 0, 0, 1'b1, 3'd2, 24'h0, 1'b0, 25'd0);
    repeat (4) pix(1'b0, 0, 0, 1'b0, 3'd0, 24'h0, 1'b0, 25'd0);
    pix(1'b1, 27, 0, 1'b0, 3'd0, 24'h0, 1'b1, {1'b1, 24'hFFFFFF});
    pix(1'b1, 26, 0, 1'b0, 3'd0, 24'h0, 1'b1, {1'b1, 24'h000000});
    pix(1'b1, 26, 32, 1'b0, 3'd0, 24'h0, 1'b1, {1'b1, 24'hFFFFFF});
    for (int i = 0; i < 30; i++)
      pix(1'b1, int'($urandom_range(1, 799)), int'($urandom_range(0, 524)),
          1'b0, 3'd0, 24'h0, 1'b0, 25'd0);
    repeat (250) pix(1'b0, 0, 0, 1'b0, 3'd0, 24'h0, 1'b0, 25'd0);
    checks++;
    if (frame_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL frame_cnt_top: got %0d required 255", frame_cnt);
    end
    pix(1'b0, 0, 0, 1'b0, 3'd0, 24'h0, 1'b0, 25'd0);
    checks++;
    if (frame_cnt !== 8'h00) begin
      errors++;
      $display("FAIL frame_cnt_wrap: got %0d required 0", frame_cnt);
    end
    for (int i = 0; i < 10; i++)
      pix(1'b1, i * 3, 0, 1'b0, 3'd0, 24'h0, 1'b0, 25'd0);
  endtask

  task automatic test_solid();
    pix(1'b1, 0,  0,  1'b1, 3'd3, 24'hABCDEF, 1'b1, {1'b1, 24'hABCDEF});
    pix(1'b1, 10, 10, 1'b0, 3'd0, 24'h123456, 1'b1, {1'b1, 24'hABCDEF});
    pix(1'b1, 20, 10, 1'b0, 3'd0, 24'h123456, 1'b1, {1'b1, 24'hABCDEF});
    pix(1'b1, 0,  0,  1'b0, 3'd0, 24'h123456, 1'b1, {1'b1, 24'h123456});
    pix(1'b0, 5,  0,  1'b0, 3'd0, 24'h123456, 1'b1, 25'd0);
  endtask

  task automatic test_reserved();
    pix(1'b1, 0,  0, 1'b1, 3'd5, 24'h0, 1'b1, {1'b1, 24'h000000});
    pix(1'b1, 44, 9, 1'b0, 3'd0, 24'h0, 1'b1, {1'b1, 24'h000000});
  endtask

  task automatic test_random();
    logic [23:0] srgb;
    int h;
    int v;
    srgb = 24'($urandom);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) srgb = 24'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        h = 0;
        v = 0;
      end else begin
        h = int'($urandom_range(0, 799));
        v = int'($urandom_range(0, 524));
      end
      pix(($urandom_range(0, 3) != 0), h, v, ($urandom_range(0, 19) == 0),
          3'($urandom_range(0, 7)), srgb, 1'b0, 25'd0);
    end
  endtask

  task automatic test_after_reset();
    pix(1'b1, 0, 0, 1'b1, 3'd2, 24'h0, 1'b0, 25'd0);
    for (int i = 0; i < 8; i++)
      pix(1'b1, i * 13, 5, 1'b0, 3'd0, 24'h0, 1'b0, 25'd0);
    test_reset("mid_frame");
    pix(1'b1, 'h1A5, 'h03C, 1'b0, 3'd0, 24'h0, 1'b1, {1'b1, 24'hA53C3C});
    pix(1'b1, 'h0F0, 'h111, 1'b0, 3'd0, 24'h0, 1'b1, {1'b1, 24'hF01111});
    pix(1'b0, 3, 3, 1'b0, 3'd0, 24'h0, 1'b0, 25'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    vidon      = 1'b0;
    hc         = 10'd5;
    vc         = 10'd5;
    mode       = 3'd0;
    mode_valid = 1'b0;
    solid_rgb  = 24'h0;
    checks     = 0;
    errors     = 0;
    m_pending  = 0;
    m_active   = 0;
    m_frame    = 0;
    m_solid    = 24'h0;
    test_reset("power_on");
    test_gradient();
    test_bars();
    test_mode_timing();
    test_checker();
    test_solid();
    test_reserved();
    test_random();
    test_after_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
